// File: rtl/and2_latch_checker_pkg.sv
// Shared types and helpers for the AND2 stimulus/response checker.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package and2_latch_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the a/b stimulus pattern counter.
  localparam int PAT_W = 2;

  // Saturating add of a 0..3 increment onto an accumulator, clamped at max.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [1:0]  inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'd0, inc};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/and2_latch_sat_counter.sv
// Saturating error accumulator: adds 0..3 per enabled cycle, clamps at all-ones.
// Latency: count visible one cycle after the enabled increment.
// Backpressure: none; clear wins over increment, reset wins over everything.
module and2_latch_sat_counter
  import and2_latch_checker_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  localparam logic [31:0] MAX = (32'd1 << W) - 32'd1;

  // Accumulate with clamping so the count never wraps back toward zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= W'(sat_add(32'(cnt), inc, MAX));
    end
  end

endmodule

// File: rtl/and2_latch_checker.sv
// Drives a/b through 00,01,10,11 and checks the DUT's comb (c) and registered (d) AND outputs.
// Latency: done rises NUM_CYCLES edges after the edge that samples start.
// Backpressure: none; start is only honoured in IDLE or DONE, ignored while running.
module and2_latch_checker
  import and2_latch_checker_pkg::*;
#(
  parameter int NUM_CYCLES = 16,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  input  logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CYC_W = (NUM_CYCLES > 2) ? $clog2(NUM_CYCLES) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] pat;
  logic [CYC_W-1:0] cyc;
  logic             d_exp;
  logic             d_exp_valid;
  logic             c_err;
  logic             d_err;
  logic             launch;
  logic             last;
  logic             running;
  logic [1:0]       inc;

  // Stimulus comes straight from the pattern register; it is parked at 00 outside RUN.
  assign a = pat[1];
  assign b = pat[0];

  // Next-state decode plus the two compares; compares only count while running.
  always_comb begin
    state_nxt = state;
    c_err     = 1'b0;
    d_err     = 1'b0;
    launch    = 1'b0;
    last      = 1'b0;
    running   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          launch    = 1'b1;
        end
      end
      RUN: begin
        running = 1'b1;
        c_err   = (c != (a & b));
        d_err   = d_exp_valid & (d != d_exp);
        if (cyc == CYC_W'(NUM_CYCLES - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    inc = {1'b0, c_err} + {1'b0, d_err};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pattern/cycle counters, d expectation pipeline and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat         <= '0;
      cyc         <= '0;
      d_exp       <= 1'b0;
      d_exp_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (launch) begin
      pat         <= '0;
      cyc         <= '0;
      d_exp       <= 1'b0;
      d_exp_valid <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (running) begin
      d_exp       <= a & b;
      d_exp_valid <= 1'b1;
      if (last) begin
        // Verdict folds in this final cycle's errors; saturation never decreases the count.
        pat         <= '0;
        cyc         <= '0;
        d_exp_valid <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= (err_cnt == '0) && (inc == 2'd0);
      end else begin
        pat <= pat + PAT_W'(1);
        cyc <= cyc + CYC_W'(1);
      end
    end
  end

  and2_latch_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (running),
    .inc (inc),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_and2_latch_checker.sv
// Directed bench: loopback DUT models with selectable faults around two checker instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_and2_latch_checker;

  localparam int NC = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;

  // Instance 1: default widths, loopback behaviour chosen by mode.
  logic       a1, b1, c1, d1, q1, busy1, done1, pass1;
  logic [7:0] err1;

  // Instance 2: 3-bit counter, both DUT outputs inverted.
  logic       a2, b2, c2, d2, q2, busy2, done2, pass2;
  logic [2:0] err2;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: correct AND + register; 1: c stuck 0, d correct; 2: c stuck 0 feeding d's register.
  assign c1 = (mode == 2'd0) ? (a1 & b1) : 1'b0;
  always @(posedge clk) q1 <= (mode == 2'd2) ? c1 : (a1 & b1);
  assign d1 = q1;

  assign c2 = ~(a2 & b2);
  always @(posedge clk) q2 <= a2 & b2;
  assign d2 = ~q2;

  and2_latch_checker #(.NUM_CYCLES(NC), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
  );

  and2_latch_checker #(.NUM_CYCLES(NC), .ERR_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, optionally poke start again at RUN index glitch_idx, and check the whole run.
  task automatic run_test(input int exp_err, input int exp_pass, input int glitch_idx);
    int edges;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", int'(busy1), 1);
    chk("start_done", int'(done1), 0);
    chk("start_err",  int'(err1),  0);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i < NC) chk("ab_seq", int'({a1, b1}), i % 4);
      start = (i == glitch_idx);
      @(posedge clk);
      #1;
      edges = i + 1;
      if (done1) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_latency", edges, NC);
    chk("end_busy", int'(busy1), 0);
    chk("end_pass", int'(pass1), exp_pass);
    chk("end_err",  int'(err1),  exp_err);
    chk("end_ab",   int'({a1, b1}), 0);
  endtask

  initial begin
    int edges;
    bit seen;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_err",  int'(err1),  0);
    chk("rst_ab",   int'({a1, b1}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", int'(done1), 0);

    // Clean loopback; the inverted instance piles up 31 errors and clamps at 7.
    mode = 2'd0;
    run_test(0, 1, -1);
    chk("sat_err",  int'(err2),  7);
    chk("sat_pass", int'(pass2), 0);
    chk("sat_done", int'(done2), 1);

    // Held in DONE with no start: flags stay put.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", int'(done1), 1);
    chk("hold_pass", int'(pass1), 1);

    // c stuck at 0: misses only where a&b=1 (indices 3,7,11,15).
    mode = 2'd1;
    run_test(4, 0, -1);

    // c stuck at 0 into d's register: adds d misses at 4,8,12. Start from DONE clears err.
    mode = 2'd2;
    run_test(7, 0, -1);

    // Reset in the middle of a run, during index 5.
    mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_err", int'(err1), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_done", int'(done1), 0);
    chk("midrst_err",  int'(err1),  0);
    chk("midrst_ab",   int'({a1, b1}), 0);
    @(posedge clk);
    #1;
    chk("midrst_idle", int'(busy1), 0);

    // Clean run after reset, with a stray start during RUN index 6.
    mode = 2'd0;
    run_test(0, 1, 6);

    // start held high: one cycle in DONE, then straight back into RUN.
    @(negedge clk);
    start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges = i + 1;
      if (done1) seen = 1'b1;
    end
    chk("held_latency", edges, NC + 1);
    @(posedge clk);
    #1;
    chk("held_restart_busy", int'(busy1), 1);
    chk("held_restart_done", int'(done1), 0);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done1) seen = 1'b1;
    end
    chk("held_final_done", int'(done1), 1);
    chk("held_final_pass", int'(pass1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
